// File: rtl/riscv_defines.sv
// Shared definitions for the string transform unit: operator codes and FSM states.
package riscv_defines;

  localparam int STR_OP_WIDTH = 3;

  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 3'd0;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 3'd1;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 3'd2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 3'd3;

  typedef enum logic [1:0] {
    STR_IDLE = 2'd0,
    STR_BUSY = 2'd1,
    STR_DONE = 2'd2
  } str_state_e;

  function automatic logic str_op_legal(input logic [STR_OP_WIDTH-1:0] op);
    case (op)
      STR_OP_UPPER, STR_OP_LOWER, STR_OP_LEET, STR_OP_ROT13: str_op_legal = 1'b1;
      default:                                               str_op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_str_byte_xform.sv
// Combinational single-byte transform; undefined operators pass the byte through.
module riscv_str_byte_xform
  import riscv_defines::*;
(
  input  logic [STR_OP_WIDTH-1:0] op_i,
  input  logic [7:0]              byte_i,
  output logic [7:0]              byte_o
);

  logic is_lower;
  logic is_upper;

  assign is_lower = (byte_i >= 8'h61) && (byte_i <= 8'h7A);
  assign is_upper = (byte_i >= 8'h41) && (byte_i <= 8'h5A);

  // Operator decode; every path defaults to passing the byte unchanged
  always_comb begin
    byte_o = byte_i;
    case (op_i)
      STR_OP_UPPER: begin
        if (is_lower) byte_o = byte_i - 8'h20;
        else          byte_o = byte_i;
      end
      STR_OP_LOWER: begin
        if (is_upper) byte_o = byte_i + 8'h20;
        else          byte_o = byte_i;
      end
      STR_OP_LEET: begin
        case (byte_i)
          8'h61, 8'h41: byte_o = 8'h34;
          8'h65, 8'h45: byte_o = 8'h33;
          8'h69, 8'h49: byte_o = 8'h31;
          8'h6F, 8'h4F: byte_o = 8'h30;
          8'h73, 8'h53: byte_o = 8'h35;
          8'h74, 8'h54: byte_o = 8'h37;
          default:      byte_o = byte_i;
        endcase
      end
      STR_OP_ROT13: begin
        // first half of each case range moves up by 13, second half wraps down
        if (is_lower)      byte_o = (byte_i <= 8'h6D) ? byte_i + 8'd13 : byte_i - 8'd13;
        else if (is_upper) byte_o = (byte_i <= 8'h4D) ? byte_i + 8'd13 : byte_i - 8'd13;
        else               byte_o = byte_i;
      end
      default: byte_o = byte_i;
    endcase
  end

endmodule

// File: rtl/riscv_str_unit.sv
// Multi-cycle string transform unit: accepts a packed operand, rewrites
// LANES_PER_CYCLE bytes per BUSY cycle and presents the result in DONE.
module riscv_str_unit
  import riscv_defines::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int LANES_PER_CYCLE = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic [STR_OP_WIDTH-1:0]              operator_i,
  input  logic [DATA_WIDTH-1:0]                operand_i,
  input  logic                                 kill_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [DATA_WIDTH-1:0]                result_o,
  output logic                                 nul_found_o,
  output logic [$clog2(DATA_WIDTH/8+1)-1:0]    nul_idx_o,
  output logic                                 illegal_o
);

  localparam int NBYTES  = DATA_WIDTH / 8;
  localparam int NGROUPS = NBYTES / LANES_PER_CYCLE;
  localparam int IDX_W   = $clog2(NBYTES + 1);
  localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  str_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     operand_q, operand_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic [STR_OP_WIDTH-1:0]   op_q, op_d;

  logic [7:0]                lane_in  [LANES_PER_CYCLE];
  logic [7:0]                lane_out [LANES_PER_CYCLE];
  logic [DATA_WIDTH-1:0]     result_next;
  logic [IDX_W-1:0]          nul_idx;
  logic                      last_group;

  // First 0x00 in the latched operand; transforms never create or remove a NUL
  always_comb begin
    nul_idx = IDX_W'(NBYTES);
    for (int i = NBYTES - 1; i >= 0; i--) begin
      if (operand_q[i*8 +: 8] == 8'h00) nul_idx = IDX_W'(i);
      else                              nul_idx = nul_idx;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES_PER_CYCLE; l++) begin
      lane_in[l] = operand_q[(int'(cnt_q) * LANES_PER_CYCLE + l) * 8 +: 8];
    end
  end

  for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
    riscv_str_byte_xform u_xform (
      .op_i   (op_q),
      .byte_i (lane_in[g]),
      .byte_o (lane_out[g])
    );
  end

  // Merge the current group into the result, leaving NUL-and-after bytes untouched
  always_comb begin
    result_next = result_q;
    for (int l = 0; l < LANES_PER_CYCLE; l++) begin
      if ((int'(cnt_q) * LANES_PER_CYCLE + l) < int'(nul_idx))
        result_next[(int'(cnt_q) * LANES_PER_CYCLE + l) * 8 +: 8] = lane_out[l];
      else
        result_next[(int'(cnt_q) * LANES_PER_CYCLE + l) * 8 +: 8] = lane_in[l];
    end
  end

  assign last_group = (cnt_q == CNT_W'(NGROUPS - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    result_d  = result_q;
    op_d      = op_q;
    case (state_q)
      STR_IDLE: begin
        if (valid_i && !kill_i) begin
          state_d   = STR_BUSY;
          cnt_d     = '0;
          operand_d = operand_i;
          result_d  = operand_i;
          op_d      = operator_i;
        end else begin
          state_d = STR_IDLE;
        end
      end
      STR_BUSY: begin
        if (kill_i) begin
          state_d = STR_IDLE;
        end else begin
          result_d = result_next;
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = last_group ? STR_DONE : STR_BUSY;
        end
      end
      STR_DONE: begin
        if (kill_i || ready_i) state_d = STR_IDLE;
        else                   state_d = STR_DONE;
      end
      default: state_d = STR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STR_IDLE;
      cnt_q     <= '0;
      operand_q <= '0;
      result_q  <= '0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      op_q      <= op_d;
    end
  end

  assign ready_o     = (state_q == STR_IDLE);
  assign valid_o     = (state_q == STR_DONE);
  assign result_o    = valid_o ? result_q : '0;
  assign nul_found_o = valid_o && (nul_idx != IDX_W'(NBYTES));
  assign nul_idx_o   = valid_o ? nul_idx : '0;
  assign illegal_o   = valid_o && !str_op_legal(op_q);

endmodule

// File: tb/tb_riscv_str_unit.sv
// Directed bench for riscv_str_unit: a 1-lane and a 4-lane instance share stimulus.
module tb_riscv_str_unit;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst, valid_i, kill_i, ready_i;
  logic [2:0]  operator_i;
  logic [31:0] operand_i;

  logic        ready_o, valid_o, nul_found_o, illegal_o;
  logic [31:0] result_o;
  logic [2:0]  nul_idx_o;
  logic        ready4, valid4, nf4, il4;
  logic [31:0] result4;
  logic [2:0]  ni4;

  int checks   = 0;
  int failures = 0;
  int lat, lat4;
  logic [31:0] held;
  logic        seen;

  always #5 clk = ~clk;

  riscv_str_unit #(.DATA_WIDTH(32), .LANES_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .operand_i(operand_i), .kill_i(kill_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .nul_found_o(nul_found_o), .nul_idx_o(nul_idx_o), .illegal_o(illegal_o)
  );

  riscv_str_unit #(.DATA_WIDTH(32), .LANES_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready4),
    .operator_i(operator_i), .operand_i(operand_i), .kill_i(kill_i),
    .valid_o(valid4), .ready_i(ready_i), .result_o(result4),
    .nul_found_o(nf4), .nul_idx_o(ni4), .illegal_o(il4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [2:0] op, input logic [31:0] data);
    @(negedge clk);
    valid_i = 1'b1; operator_i = op; operand_i = data;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Counts edges after the accepting edge until each instance shows valid_o
  task automatic wait_done();
    lat = 0; lat4 = 0;
    while (!valid_o && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (valid4 && lat4 == 0) lat4 = lat;
    end
  endtask

  task automatic handshake();
    @(negedge clk); ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk); ready_i = 1'b0;
    chk("hs_ready", 32'(ready_o), 32'd1);
    chk("hs_valid", 32'(valid_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
    operator_i = 3'd0; operand_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  32'(ready_o),     32'd1);
    chk("rst_valid",  32'(valid_o),     32'd0);
    chk("rst_result", result_o,         32'h0);
    chk("rst_nulidx", 32'(nul_idx_o),   32'd0);
    rst = 1'b0;

    // UPPER
    accept(STR_OP_UPPER, 32'h6C6C6568);
    chk("busy_ready",  32'(ready_o),  32'd0);
    chk("busy_result", result_o,      32'h0);
    chk("busy_nulf",   32'(nul_found_o), 32'd0);
    wait_done();
    chk("up_lat",   32'(lat),         32'd4);
    chk("up_lat4",  32'(lat4),        32'd1);
    chk("up_res",   result_o,         32'h4C4C4548);
    chk("up_res4",  result4,          32'h4C4C4548);
    chk("up_nulf",  32'(nul_found_o), 32'd0);
    chk("up_nuli",  32'(nul_idx_o),   32'd4);
    chk("up_ill",   32'(illegal_o),   32'd0);
    handshake();

    // ROT13 and LEET
    accept(STR_OP_ROT13, 32'h7A6D415A);
    wait_done();
    chk("rot_lat",  32'(lat),  32'd4);
    chk("rot_lat4", 32'(lat4), 32'd1);
    chk("rot_res",  result_o,  32'h6D7A4E4D);
    chk("rot_res4", result4,   32'h6D7A4E4D);
    handshake();
    accept(STR_OP_LEET, 32'h74736F65);
    wait_done();
    chk("leet_lat4", 32'(lat4), 32'd1);
    chk("leet_res",  result_o,  32'h37353033);
    chk("leet_res4", result4,   32'h37353033);
    handshake();

    // Undefined operator with ready_i held low
    accept(3'd7, 32'h12345678);
    wait_done();
    chk("ill_res",  result_o,        32'h12345678);
    chk("ill_flag", 32'(illegal_o),  32'd1);
    chk("ill_flag4", 32'(il4),       32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_res",   result_o,       32'h12345678);
      chk("hold_ill",   32'(illegal_o), 32'd1);
      chk("hold_valid", 32'(valid_o),   32'd1);
      chk("hold_ready", 32'(ready_o),   32'd0);
    end
    handshake();

    // LOWER with embedded NUL, then a back-to-back request
    accept(STR_OP_LOWER, 32'h41004161);
    wait_done();
    chk("lo_res",  result_o,         32'h41006161);
    chk("lo_nulf", 32'(nul_found_o), 32'd1);
    chk("lo_nuli", 32'(nul_idx_o),   32'd2);
    chk("lo_res4", result4,          32'h41006161);
    @(negedge clk);
    ready_i = 1'b1; valid_i = 1'b1; operator_i = STR_OP_UPPER; operand_i = 32'h6C6C6568;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
    chk("b2b_idle",  32'(ready_o), 32'd1);
    chk("b2b_valid", 32'(valid_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    chk("b2b_acc", 32'(ready_o), 32'd0);
    wait_done();
    chk("b2b_lat", 32'(lat),  32'd4);
    chk("b2b_res", result_o,  32'h4C4C4548);
    handshake();

    // kill_i in IDLE blocks acceptance
    @(negedge clk);
    valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0; kill_i = 1'b0;
    chk("kill_idle", 32'(ready_o), 32'd1);

    // kill_i in the 2nd BUSY cycle
    accept(STR_OP_UPPER, 32'h6C6C6568);
    @(posedge clk);
    @(negedge clk);
    kill_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill_ready", 32'(ready_o), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    chk("kill_novalid", 32'(seen), 32'd0);

    // rst while in DONE
    accept(STR_OP_LOWER, 32'h41004161);
    wait_done();
    held = result_o;
    chk("pre_rst_res", held, 32'h41006161);
    @(negedge clk);
    rst = 1'b1; kill_i = 1'b1; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; kill_i = 1'b0; valid_i = 1'b0;
    chk("drst_ready",  32'(ready_o),     32'd1);
    chk("drst_valid",  32'(valid_o),     32'd0);
    chk("drst_result", result_o,         32'h0);
    chk("drst_nulf",   32'(nul_found_o), 32'd0);
    chk("drst_nuli",   32'(nul_idx_o),   32'd0);
    chk("drst_ill",    32'(illegal_o),   32'd0);
    chk("drst_valid4", 32'(valid4),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
